// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers for a MIPS-style datapath.
// Shift-add multiply and restoring divide on magnitudes, one bit per clock, sign fixed at the end.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic               last;

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend} for divide
  always_comb begin
    a_mag    = (op[0] && a[WIDTH-1]) ? -a : a;
    b_mag    = (op[0] && b[WIDTH-1]) ? -b : b;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_ge   = (rem_sh >= {1'b0, opnd});
    rem_new  = div_ge ? WIDTH'(rem_sh - {1'b0, opnd}) : rem_sh[WIDTH-1:0];
    acc_nxt  = is_div ? {rem_new, acc[WIDTH-2:0], div_ge} : {mul_sum, acc[WIDTH-1:1]};
    prod_fix = cond_neg2(acc_nxt, neg_res);
    last     = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      if (state == CALC) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (is_div) begin
            lo <= cond_neg(acc_nxt[WIDTH-1:0], neg_res);
            hi <= cond_neg(acc_nxt[2*WIDTH-1:WIDTH], neg_rem);
          end else begin
            lo <= prod_fix[WIDTH-1:0];
            hi <= prod_fix[2*WIDTH-1:WIDTH];
          end
        end
      end else if (start) begin
        // a zero divisor never enters CALC; the raw dividend lands in hi
        if (op[1] && (b == '0)) begin
          lo    <= '1;
          hi    <= a;
          state <= DONE;
          done  <= 1'b1;
        end else begin
          state   <= CALC;
          busy    <= 1'b1;
          cnt     <= '0;
          is_div  <= op[1];
          neg_res <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem <= op[0] & op[1] & a[WIDTH-1];
          opnd    <= op[1] ? b_mag : a_mag;
          acc     <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
        end
      end else begin
        state <= IDLE;
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with HI/LO result registers. It extends the single-cycle MIPS datapath with MULT/MULTU/DIV/DIVU and MFHI/MFLO/MTHI/MTLO support. It is parametrised in operand width and supports signed and unsigned modes. The controller stalls the PC while busy is high and reads hi/lo directly for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits, split across hi and lo.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request an operation; sampled only in IDLE or DONE
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
hi_we  input  1  MTHI: write wdata into hi
lo_we  input  1  MTLO: write wdata into lo
wdata  input  WIDTH  data for MTHI/MTLO
busy  output  1  high while in CALC
done  output  1  one-cycle pulse; hi/lo valid and updated
hi  output  WIDTH  HI register (product upper half / remainder)
lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0. Reset mid-operation aborts the operation with no hi/lo update.
- FSM states: IDLE, CALC, DONE.
  - IDLE/DONE with start=1: latch operands, go to CALC with counter=0.
  - Exception: divide with b==0 goes straight to DONE.
  - DONE always lasts one cycle, then returns to IDLE unless start=1.
- Operand conditioning:
  - Signed ops (op[0]=1) latch |a| and |b|, plus neg_res and neg_rem flags.
  - Multiply: neg_res = a[W-1]^b[W-1].
  - Divide: neg_res (quotient sign) = a[W-1]^b[W-1]; neg_rem (remainder sign) = a[W-1].
  - Unsigned ops use the operands unchanged with both flags cleared.
- CALC: one iteration per clock, exactly WIDTH iterations.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle, MSB first.
  - On the edge completing iteration WIDTH-1:
    - apply sign correction (two's-complement negate of the 2W product, or of the quotient/remainder);
    - write hi/lo and enter DONE.
- Latency: start sampled at edge 0 -> done=1 during the cycle after edge WIDTH, i.e. WIDTH+1 cycles after the start cycle. busy=1 for exactly WIDTH cycles.
- Divide by zero: the edge sampling start writes lo={WIDTH{1'b1}} and hi=a (raw, uncorrected), then enters DONE. done pulses the next cycle and busy never asserts.
- Signed overflow (DIV MIN/-1): lo=MIN, hi=0. This is the natural result of magnitude division plus negation and needs no special case.
- start while in CALC is ignored; the operation continues.
- hi_we/lo_we:
  - honoured only in IDLE/DONE when start=0; both may be set in the same cycle;
  - ignored in CALC;
  - if start=1 in the same cycle, start wins and the writes are dropped.
- hi/lo are held between operations. They change only on operation completion, MTHI/MTLO, or reset.
- done is a registered output, high only in DONE.

Test Plan:
1. WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 32 cycles, done pulses once at cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
2. MULT a=-3 (0xFFFFFFFD) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
3. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=7 -> lo=14, hi=2; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU a=5 b=0 -> busy stays 0, done the cycle after start, lo=0xFFFFFFFF, hi=5.
5. MULTU 6*7 started, then start with different operands plus hi_we=1 at cycle 5 -> both ignored, result hi=0 lo=42. Then hi_we=1 wdata=0x1234 in IDLE -> hi=0x1234. Then start a new op, pull rst low at cycle 10 -> busy=0, done=0, hi=lo=0 immediately (async). After release, MULTU 3*4 -> lo=12.
6. WIDTH=8: MULTU 200*200 -> done after 9 cycles, hi=0x9C, lo=0x40; DIV -128/3 -> lo=0xD6 (-42), hi=0xFE (-2).
